// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: serialises host configuration words MSB-first onto the PAL configuration shift chain.
module pal_cfg_loader #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         ABORT,
  input  logic [W-1:0] DATA_IN,
  input  logic         DATA_VALID,
  output logic         DATA_READY,
  output logic         CFG_OUT,
  output logic         CFG_EN,
  output logic         BUSY,
  output logic         DONE
);
  localparam int SR_LEN = 2*N + (N+M)*P;
  localparam int RW = $clog2(SR_LEN+1);
  localparam int BW = $clog2(W+1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;
  state_t state;
  logic [W-1:0] hold;
  logic [RW-1:0] rem;
  logic [BW-1:0] bcnt;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      hold <= '0;
      rem <= '0;
      bcnt <= '0;
    end else if (ABORT && state != IDLE) state <= IDLE;
    else
      case (state)
        IDLE: if (START) begin
          state <= LOAD;
          rem <= RW'(SR_LEN);
          bcnt <= '0;
        end
        LOAD: if (DATA_VALID) begin
          state <= SHIFT;
          hold <= DATA_IN;
          // the final word only contributes its top rem bits
          bcnt <= (int'(rem) < W) ? BW'(rem) : BW'(W);
        end
        SHIFT: begin
          hold <= hold << 1;
          bcnt <= bcnt - BW'(1);
          rem <= rem - RW'(1);
          if (bcnt == BW'(1)) state <= (rem == RW'(1)) ? FIN : LOAD;
        end
        FIN: state <= IDLE;
      endcase
  assign DATA_READY = state == LOAD;
  assign CFG_EN = state == SHIFT;
  assign CFG_OUT = CFG_EN & hold[W-1];
  assign BUSY = state != IDLE;
  assign DONE = state == FIN;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: directed checks of a 12-bit chain and the default 144-bit chain.
module tb_pal_cfg_loader;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic s_start = 0, s_abort = 0, s_valid = 0, s_ready, s_out, s_en, s_busy, s_done;
  logic [7:0] s_data = '0;
  logic d_start = 0, d_abort = 0, d_valid = 0, d_ready, d_out, d_en, d_busy, d_done;
  logic [7:0] d_data = '0;
  pal_cfg_loader #(.N(2), .M(2), .P(2), .W(8)) u_s (
    .CLK(clk), .RST(rst), .START(s_start), .ABORT(s_abort), .DATA_IN(s_data),
    .DATA_VALID(s_valid), .DATA_READY(s_ready), .CFG_OUT(s_out), .CFG_EN(s_en),
    .BUSY(s_busy), .DONE(s_done));
  pal_cfg_loader u_d (
    .CLK(clk), .RST(rst), .START(d_start), .ABORT(d_abort), .DATA_IN(d_data),
    .DATA_VALID(d_valid), .DATA_READY(d_ready), .CFG_OUT(d_out), .CFG_EN(d_en),
    .BUSY(d_busy), .DONE(d_done));
  int n_cmp = 0, n_err = 0, ncyc = 0;
  int s_nen, s_ndone, s_t0, s_tdone, d_nen, d_ndone, d_t0, d_tdone;
  logic [11:0] s_chain = '0;
  logic [143:0] d_chain = '0, d_exp = '0;
  logic [7:0] d_w [18];
  logic d_hs = 0;
  // behavioural chain models and event counters, sampled mid-cycle
  always @(negedge clk) begin
    ncyc++;
    if (s_start && !s_busy) s_t0 = ncyc;
    if (s_en) begin s_chain = {s_chain[10:0], s_out}; s_nen++; end
    if (s_done) begin s_ndone++; s_tdone = ncyc - s_t0; end
    if (d_start && !d_busy) d_t0 = ncyc;
    if (d_en) begin d_chain = {d_chain[142:0], d_out}; d_nen++; end
    if (d_done) begin d_ndone++; d_tdone = ncyc - d_t0; end
    d_hs = d_valid && d_ready;
  end
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    s_nen = 0; s_ndone = 0; s_tdone = 0;
    d_nen = 0; d_ndone = 0; d_tdone = 0;
  endtask
  task automatic s_basic(input string tag);
    clr;
    s_valid = 1; s_data = 8'hA5; s_start = 1;
    tick;
    s_start = 0;
    tick;
    s_data = 8'h3C;
    repeat (25) tick;
    s_valid = 0;
    check({tag, "_chain"}, s_chain, 12'hA53);
    check({tag, "_nen"}, s_nen, 12);
    check({tag, "_ndone"}, s_ndone, 1);
    check({tag, "_lat"}, s_tdone, 15);
    check({tag, "_busy"}, s_busy, 0);
  endtask
  initial begin
    repeat (3) tick;
    check("rst_ready", s_ready, 0);
    check("rst_out", s_out, 0);
    check("rst_en", s_en, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    rst = 0;
    tick;
    s_basic("short");
    clr;
    s_valid = 1; s_data = 8'hA5; s_start = 1;
    tick;
    s_start = 0;
    tick;
    s_valid = 0; s_data = 8'h3C;
    for (int i = 0; i < 20 && !s_ready; i++) tick;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", s_ready, 1);
      check("stall_en", s_en, 0);
      tick;
    end
    s_valid = 1;
    repeat (20) tick;
    s_valid = 0;
    check("stall_chain", s_chain, 12'hA53);
    check("stall_nen", s_nen, 12);
    check("stall_lat", s_tdone, 20);
    clr;
    s_valid = 1; s_data = 8'hA5; s_start = 1;
    tick;
    s_start = 0;
    tick;
    s_data = 8'h3C;
    repeat (11) tick;
    check("ab_en_pre", s_en, 1);
    s_abort = 1;
    tick;
    s_abort = 0;
    check("ab_en", s_en, 0);
    check("ab_busy", s_busy, 0);
    repeat (5) tick;
    s_valid = 0;
    check("ab_ndone", s_ndone, 0);
    check("ab_nen", s_nen, 11);
    s_basic("ab_re");
    s_valid = 1; s_data = 8'hA5; s_start = 1;
    tick;
    s_start = 0;
    repeat (4) tick;
    check("rs_en_pre", s_en, 1);
    rst = 1;
    tick;
    rst = 0;
    check("rs_ready", s_ready, 0);
    check("rs_out", s_out, 0);
    check("rs_en", s_en, 0);
    check("rs_busy", s_busy, 0);
    check("rs_done", s_done, 0);
    s_basic("rs_re");
    clr;
    s_valid = 1; s_data = 8'hA5; s_start = 1;
    tick;
    for (int i = 0; i < 11; i++) begin
      s_start = ~i[0];
      tick;
      if (i == 0) s_data = 8'h3C;
    end
    s_start = 0;
    repeat (20) tick;
    s_valid = 0;
    check("ign_ndone", s_ndone, 1);
    check("ign_nen", s_nen, 12);
    check("ign_chain", s_chain, 12'hA53);
    check("ign_lat", s_tdone, 15);
    for (int k = 0; k < 18; k++) begin
      d_w[k] = 8'($urandom);
      d_exp = {d_exp[135:0], d_w[k]};
    end
    clr;
    begin
      int k;
      k = 0;
      d_data = d_w[0]; d_valid = 1; d_start = 1;
      tick;
      d_start = 0;
      repeat (200) begin
        tick;
        if (d_hs && k < 17) begin k++; d_data = d_w[k]; end
      end
    end
    d_valid = 0;
    check("def_chain", d_chain, d_exp);
    check("def_nen", d_nen, 144);
    check("def_ndone", d_ndone, 1);
    check("def_lat", d_tdone, 163);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
